// File: rtl/mmcm_reset_sequencer.sv
// ---------------------------------------------------------------------------
// mmcm_reset_sequencer
//
// Purpose:
//   Sequences the reset of an MMCM running from the same reference clock.
//   The MMCM is held in reset for a fixed number of cycles and then released.
//   Lock is declared stable only after LOCKED has been high for a run of
//   consecutive samples. If lock does not arrive within the timeout window,
//   the MMCM is reset again. After too many consecutive timeouts, the block
//   parks in a fault state until the next external reset. A lock loss while
//   running restarts the reset sequence and is counted.
//
// Ports:
//   CLK          in   free-running reference clock; all logic runs on it
//   ASYNC_RESET  in   asynchronous active-high reset
//   LOCKED_IN    in   MMCM LOCKED, asynchronous to CLK
//   MMCM_RST     out  MMCM reset, registered
//   LOCK_STABLE  out  filtered lock status, registered
//   FAULT        out  retry budget exhausted, registered
//   RETRY_COUNT  out  consecutive timeouts since last entry to RUN (sat. 255)
//   LOSS_COUNT   out  lock losses seen in RUN since reset (sat. 255)
// ---------------------------------------------------------------------------
module mmcm_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_FILTER_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 125000,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       CLK,
    input  logic       ASYNC_RESET,
    input  logic       LOCKED_IN,
    output logic       MMCM_RST,
    output logic       LOCK_STABLE,
    output logic       FAULT,
    output logic [7:0] RETRY_COUNT,
    output logic [7:0] LOSS_COUNT
);

    // Each counter only has to hold values up to limit-1, because the
    // transition is taken on the cycle the counter sits at limit-1.
    // A limit of 1 would give a zero-width counter, so the width is
    // floored at one bit.
    localparam int HOLD_W = (RST_HOLD_CYCLES     > 1) ? $clog2(RST_HOLD_CYCLES)     : 1;
    localparam int FILT_W = (LOCK_FILTER_CYCLES  > 1) ? $clog2(LOCK_FILTER_CYCLES)  : 1;
    localparam int TMO_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_next;
    logic [FILT_W-1:0]  filt_cnt, filt_cnt_next;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_next;
    logic [7:0]         retry_next, loss_next, retry_inc;
    logic               lock_meta, lock_sync;

    // Two-flop synchronizer for the asynchronous LOCKED input. Nothing
    // else in the block looks at LOCKED_IN directly.
    always_ff @(posedge CLK or posedge ASYNC_RESET) begin
        if (ASYNC_RESET) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= LOCKED_IN;
            lock_sync <= lock_meta;
        end
    end

    // State, counters and outputs. The outputs are decoded from the next
    // state, so they change on the same edge as the state itself.
    always_ff @(posedge CLK or posedge ASYNC_RESET) begin
        if (ASYNC_RESET) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            filt_cnt    <= '0;
            tmo_cnt     <= '0;
            RETRY_COUNT <= 8'd0;
            LOSS_COUNT  <= 8'd0;
            MMCM_RST    <= 1'b1;
            LOCK_STABLE <= 1'b0;
            FAULT       <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_cnt_next;
            filt_cnt    <= filt_cnt_next;
            tmo_cnt     <= tmo_cnt_next;
            RETRY_COUNT <= retry_next;
            LOSS_COUNT  <= loss_next;
            MMCM_RST    <= (state_next == ST_HOLD) || (state_next == ST_FAULT);
            LOCK_STABLE <= (state_next == ST_RUN);
            FAULT       <= (state_next == ST_FAULT);
        end
    end

    // Next-state logic. Counters default to zero, so any state change
    // clears them. They only advance while the state stays put.
    always_comb begin
        state_next    = state;
        hold_cnt_next = '0;
        filt_cnt_next = '0;
        tmo_cnt_next  = '0;
        retry_next    = RETRY_COUNT;
        loss_next     = LOSS_COUNT;
        retry_inc     = (RETRY_COUNT == 8'hFF) ? 8'hFF : RETRY_COUNT + 8'd1;

        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = ST_WAIT_LOCK;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                // The filter is checked first, so a lock that completes
                // on the last timeout cycle still counts as a lock.
                if (lock_sync && (filt_cnt == FILT_LAST)) begin
                    state_next = ST_RUN;
                    retry_next = 8'd0;
                end else if (tmo_cnt == TMO_LAST) begin
                    retry_next = retry_inc;
                    if (int'(retry_inc) > MAX_RETRIES) begin
                        state_next = ST_FAULT;
                    end else begin
                        state_next = ST_HOLD;
                    end
                end else begin
                    filt_cnt_next = lock_sync ? (filt_cnt + FILT_W'(1)) : '0;
                    tmo_cnt_next  = tmo_cnt + TMO_W'(1);
                end
            end

            ST_RUN: begin
                if (!lock_sync) begin
                    state_next = ST_HOLD;
                    loss_next  = (LOSS_COUNT == 8'hFF) ? 8'hFF : LOSS_COUNT + 8'd1;
                end
            end

            ST_FAULT: begin
                state_next = ST_FAULT;
            end

            default: begin
                state_next = ST_HOLD;
            end
        endcase
    end

endmodule
